cpu_data_lsu: RTL and testbench
===============================

// Module: cpu_data_lsu
// PURPOSE
//  Load/store unit between the multicycle RV32I core's memory-access stage and the data-port BRAM.
//  Accepts one load/store request at a time and performs byte-lane alignment and write-enable generation.
//  Waits out the BRAM read latency, then extracts and sign- or zero-extends load data.
//  Flags misaligned or illegal accesses without touching memory.
// PARAMETERS
//  RD_LATENCY     1  BRAM read latency in cycles, legal 1..8.
//  MEM_WORD_ADDR  1  1: addr_data = word address {2'b0,addr[31:2]}; 0: byte address {addr[31:2],2'b00}.
// PORTS
//  aclk           in   1   Clock, rising edge.
//  areset         in   1   Synchronous reset, active-high.
//  req_valid      in   1   Core presents a request.
//  req_ready      out  1   LSU can accept; high only in IDLE and with areset low.
//  req_we         in   1   1 = store, 0 = load.
//  req_funct3     in   3   RV32I funct3: LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2.
//  req_addr       in   32  Byte address (rs1 + imm).
//  req_wdata      in   32  Store data (rs2).
//  resp_valid     out  1   One-cycle pulse: request complete.
//  resp_rdata     out  32  Extended load data; 0 for stores and errors.
//  resp_err       out  1   Valid with resp_valid; 1 = misaligned or illegal funct3.
//  addr_data      out  32  BRAM address.
//  data_out_data  out  32  BRAM write data, lane-replicated.
//  data_in_data   in   32  BRAM read data.
//  en_data        out  1   BRAM enable.
//  we_data        out  4   BRAM byte write enables; bit i = byte lane i (little-endian).
// BEHAVIOUR
//  Design decision: one clock, aclk; areset is synchronous and active-high.
//  Reset values (all outputs): req_ready 0 while areset is high, resp_valid 0, resp_rdata 0, resp_err 0,
//   en_data 0, we_data 0, addr_data 0, data_out_data 0.
//  Reset mid-operation: the transaction is abandoned; no resp_valid; state returns to IDLE.
//  States: IDLE, ISSUE, WAIT, CAPT, RESP.
//  IDLE:
//   - req_ready = 1.
//   - On req_valid at edge k: latch we/funct3/addr/wdata.
//   - Legal request: go to ISSUE. Illegal request: go to RESP with err = 1.
//  Illegal request:
//   - Load funct3 in {3,6,7}, or store funct3 >= 3.
//   - LH/LHU/SH with addr[0] = 1.
//   - LW/SW with addr[1:0] != 0.
//  ISSUE (cycle k+1):
//   - en_data = 1 for exactly this cycle.
//   - addr_data driven from the latched address.
//   - Store: we_data asserted this cycle, then go to RESP.
//   - Load: we_data = 0, then go to WAIT, or to CAPT if RD_LATENCY = 1.
//  WAIT: counts RD_LATENCY-1 cycles; en_data = 0.
//  CAPT (cycle k+1+RD_LATENCY): samples data_in_data, extracts and extends it into resp_rdata, then goes to RESP.
//  RESP: resp_valid = 1 for one cycle, then back to IDLE. req_ready is 0 here, so back-to-back accepts are one
//   cycle after resp.
//  Response latency from accept edge k:
//   - store: resp_valid in cycle k+2.
//   - load: resp_valid in cycle k+2+RD_LATENCY.
//   - error: resp_valid in cycle k+1.
//  Error response: en_data and we_data are never asserted; resp_rdata = 0.
//  Store lanes:
//   - SB: data_out_data = {4{wdata[7:0]}}, we_data = 4'b0001 << addr[1:0].
//   - SH: data_out_data = {2{wdata[15:0]}}, we_data = 4'b0011 << addr[1:0].
//   - SW: data_out_data = wdata, we_data = 4'b1111.
//  Load extract:
//   - Byte = data_in_data[8*addr[1:0] +: 8]; half = data_in_data[16*addr[1] +: 16].
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
//  Outside ISSUE: en_data = 0 and we_data = 0; addr_data and data_out_data hold their last values.
//  req_valid while busy is ignored; the core must hold its request until req_ready.
// TESTING
//  Test 1, reset then idle:
//   - Stimulus: reset, then idle.
//   - Required: req_ready = 1 the cycle after areset drops; en_data = 0, we_data = 0, resp_valid = 0.
//  Test 2, SB store:
//   - Stimulus: SB, addr 0x103, wdata 0xAABBCC5A.
//   - Required: ISSUE has we_data = 1000, data_out_data = 0x5A5A5A5A, addr_data = 0x40 (MEM_WORD_ADDR = 1);
//     resp_valid at k+2 with err = 0.
//  Test 3, LB/LBU/LH/LW, RD_LATENCY = 1, BRAM word 0x80FF7F01:
//   - LB addr 1 -> 0x0000007F.
//   - LB addr 3 -> 0xFFFFFF80.
//   - LBU addr 2 -> 0x000000FF.
//   - LH addr 2 -> 0xFFFF80FF.
//   - LW -> 0x80FF7F01.
//   - Each response arrives at k+3.
//  Test 4, RD_LATENCY = 3:
//   - Stimulus: LW.
//   - Required: resp_valid at k+5; en_data high only at k+1.
//  Test 5, misaligned and illegal:
//   - LW addr 0x2 -> resp_err = 1 at k+1, en_data never high.
//   - SH addr 0x1 -> same.
//   - Load funct3 = 7 -> same.
//  Test 6, reset and busy handling:
//   - areset pulsed in WAIT -> no resp_valid, req_ready = 1 the cycle after release.
//   - req_valid held during RESP -> accepted only in the following IDLE cycle.

Source files
------------

// File: rtl/cpu_data_lsu.sv
// Load/store unit between the RV32I core memory stage and the data-port BRAM.
// Handles one request at a time: lane alignment and byte enables for stores,
// waits out the BRAM read latency for loads, then extracts and extends the
// loaded data. Misaligned or illegal requests are answered with an error and
// never reach the BRAM.
`timescale 1ns/1ps
module cpu_data_lsu #(
  parameter int unsigned RD_LATENCY    = 1,    // BRAM read latency, 1..8
  parameter bit          MEM_WORD_ADDR = 1'b1  // 1: word address, 0: byte address
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr_data,
  output logic [31:0] data_out_data,
  input  logic [31:0] data_in_data,
  output logic        en_data,
  output logic [3:0]  we_data
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapt, StResp} state_e;

  // WAIT lasts RD_LATENCY-1 cycles; the counter runs from this value down to 0.
  localparam logic [2:0] WaitInit = (RD_LATENCY >= 2) ? 3'(RD_LATENCY - 2) : 3'd0;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  wait_cnt_q;

  logic        req_illegal;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] req_mem_addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign req_ready = (state_q == StIdle) && !areset;

  // Decode the incoming request: legality, store lane data and byte enables.
  always_comb begin
    req_illegal = 1'b0;
    st_mask     = 4'b0000;
    st_data     = req_wdata;
    unique case (req_funct3)
      3'd0: begin
        st_mask = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      3'd1: begin
        st_mask     = 4'b0011 << req_addr[1:0];
        st_data     = {2{req_wdata[15:0]}};
        req_illegal = req_addr[0];
      end
      3'd2: begin
        st_mask     = 4'b1111;
        req_illegal = |req_addr[1:0];
      end
      3'd4:    req_illegal = req_we;
      3'd5:    req_illegal = req_we | req_addr[0];
      default: req_illegal = 1'b1;
    endcase
    req_mem_addr = MEM_WORD_ADDR ? {2'b00, req_addr[31:2]} : {req_addr[31:2], 2'b00};
  end

  // Pick the addressed byte/half out of the BRAM word and extend it.
  always_comb begin
    unique case (addr_lo_q)
      2'd0:    ld_byte = data_in_data[7:0];
      2'd1:    ld_byte = data_in_data[15:8];
      2'd2:    ld_byte = data_in_data[23:16];
      default: ld_byte = data_in_data[31:24];
    endcase
    ld_half = addr_lo_q[1] ? data_in_data[31:16] : data_in_data[15:0];
    unique case (funct3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = data_in_data;
    endcase
  end

  // Request FSM with registered BRAM strobes and response outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      funct3_q      <= 3'd0;
      addr_lo_q     <= 2'd0;
      wait_cnt_q    <= 3'd0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_err      <= 1'b0;
      addr_data     <= 32'd0;
      data_out_data <= 32'd0;
      en_data       <= 1'b0;
      we_data       <= 4'b0000;
    end else begin
      // Strobes are single-cycle; only the transition into ISSUE/RESP raises them.
      en_data    <= 1'b0;
      we_data    <= 4'b0000;
      resp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            if (req_illegal) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state_q   <= StIssue;
              en_data   <= 1'b1;
              addr_data <= req_mem_addr;
              if (req_we) begin
                we_data       <= st_mask;
                data_out_data <= st_data;
              end
            end
          end
        end
        StIssue: begin
          if (we_q) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
          end else if (RD_LATENCY <= 1) begin
            state_q <= StCapt;
          end else begin
            state_q    <= StWait;
            wait_cnt_q <= WaitInit;
          end
        end
        StWait: begin
          if (wait_cnt_q == 3'd0) begin
            state_q <= StCapt;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        StCapt: begin
          state_q    <= StResp;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= ld_data;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_data_lsu.sv
// Directed bench for cpu_data_lsu: one instance at read latency 1 and one at
// read latency 3, each in front of a small BRAM model that only presents valid
// data in the exact cycle the latency allows.
`timescale 1ns/1ps
module tb_cpu_data_lsu;

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid1, req_valid3;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        ready1, rv1, err1, en1;
  logic [31:0] rdata1, addr1, dout1, din1;
  logic [3:0]  we1;
  logic        ready3, rv3, err3, en3;
  logic [31:0] rdata3, addr3, dout3, din3;
  logic [3:0]  we3;

  logic [31:0] mem [0:255];
  logic [31:0] p3a, p3b;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  cpu_data_lsu #(.RD_LATENCY(1), .MEM_WORD_ADDR(1'b1)) dut1 (
    .aclk(aclk), .areset(areset), .req_valid(req_valid1), .req_ready(ready1),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rdata1), .resp_err(err1), .addr_data(addr1),
    .data_out_data(dout1), .data_in_data(din1), .en_data(en1), .we_data(we1)
  );

  cpu_data_lsu #(.RD_LATENCY(3), .MEM_WORD_ADDR(1'b1)) dut3 (
    .aclk(aclk), .areset(areset), .req_valid(req_valid3), .req_ready(ready3),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rdata3), .resp_err(err3), .addr_data(addr3),
    .data_out_data(dout3), .data_in_data(din3), .en_data(en3), .we_data(we3)
  );

  // BRAM models: garbage outside the single valid read cycle.
  always @(posedge aclk) begin
    if (en1) begin
      for (int i = 0; i < 4; i++) begin
        if (we1[i]) mem[addr1[7:0]][8*i +: 8] <= dout1[8*i +: 8];
      end
    end
    din1 <= (en1 && we1 == 4'b0000) ? mem[addr1[7:0]] : 32'hDEADBEEF;
    p3a  <= en3 ? mem[addr3[7:0]] : 32'hDEADBEEF;
    p3b  <= p3a;
    din3 <= p3b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Present a request for one accept edge; returns in cycle k+1.
  task automatic issue(input bit sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    if (sel) req_valid3 = 1'b1;
    else     req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
  endtask

  // Walk forward to resp_valid; lat counts cycles from k (cycle k+1 is lat 1).
  task automatic track(input bit sel, output int lat, output int en_cnt, output int en_first,
                       output logic [31:0] rd, output logic er);
    lat      = 1;
    en_cnt   = 0;
    en_first = 0;
    while (!(sel ? rv3 : rv1) && lat < 20) begin
      if (sel ? en3 : en1) begin
        en_cnt++;
        if (en_first == 0) en_first = lat;
      end
      step();
      lat++;
    end
    rd = sel ? rdata3 : rdata1;
    er = sel ? err3 : err1;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    int lat, en_cnt, en_first;
    logic [31:0] rd;
    logic er;
    issue(1'b0, 1'b0, f3, a, 32'd0);
    track(1'b0, lat, en_cnt, en_first, rd, er);
    check({tag, "_lat"}, lat, 3);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, er, 1'b0);
    step();
  endtask

  task automatic run_bad(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a);
    int lat, en_cnt, en_first;
    logic [31:0] rd;
    logic er;
    issue(1'b0, we, f3, a, 32'hFFFF_FFFF);
    track(1'b0, lat, en_cnt, en_first, rd, er);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_err"}, er, 1'b1);
    check({tag, "_rdata"}, rd, 32'd0);
    check({tag, "_we"}, we1, 4'b0000);
    step();
    check({tag, "_en"}, en1 + en_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, en_cnt, en_first, hits;
    logic [31:0] rd;
    logic er;

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'h80FF7F01;
    areset = 1'b1;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;

    // Test 1: reset values, then idle.
    repeat (3) step();
    check("rst_ready1", ready1, 1'b0);
    check("rst_ready3", ready3, 1'b0);
    check("rst_rv", rv1, 1'b0);
    check("rst_en", en1, 1'b0);
    check("rst_we", we1, 4'b0000);
    check("rst_addr", addr1, 32'd0);
    check("rst_dout", dout1, 32'd0);
    check("rst_rdata", rdata1, 32'd0);
    check("rst_err", err1, 1'b0);
    areset = 1'b0;
    #1;
    check("rel_ready", ready1, 1'b1);
    step();
    check("idle_ready", ready1, 1'b1);
    check("idle_en", en1, 1'b0);
    check("idle_we", we1, 4'b0000);
    check("idle_rv", rv1, 1'b0);

    // Test 2: SB to 0x103.
    issue(1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'hAABBCC5A);
    check("sb_en", en1, 1'b1);
    check("sb_we", we1, 4'b1000);
    check("sb_dout", dout1, 32'h5A5A5A5A);
    check("sb_addr", addr1, 32'h0000_0040);
    check("sb_ready", ready1, 1'b0);
    step();
    check("sb_rv", rv1, 1'b1);
    check("sb_err", err1, 1'b0);
    check("sb_en_off", en1, 1'b0);
    check("sb_we_off", we1, 4'b0000);
    step();
    run_load("sb_readback", 3'd2, 32'h0000_0100, 32'h5A000000);

    // SH into the same word, then half loads from it.
    issue(1'b0, 1'b1, 3'd1, 32'h0000_0102, 32'h1234BEEF);
    check("sh_we", we1, 4'b1100);
    check("sh_dout", dout1, 32'hBEEFBEEF);
    track(1'b0, lat, en_cnt, en_first, rd, er);
    check("sh_lat", lat, 2);
    check("sh_rdata", rd, 32'd0);
    step();
    run_load("lh_neg", 3'd1, 32'h0000_0102, 32'hFFFFBEEF);
    run_load("lhu", 3'd5, 32'h0000_0102, 32'h0000BEEF);
    run_load("sh_readback", 3'd2, 32'h0000_0100, 32'hBEEF0000);

    // Test 3: extraction from 0x80FF7F01 at latency 1.
    run_load("lb1", 3'd0, 32'h1, 32'h0000007F);
    run_load("lb3", 3'd0, 32'h3, 32'hFFFFFF80);
    run_load("lbu2", 3'd4, 32'h2, 32'h000000FF);
    run_load("lh2", 3'd1, 32'h2, 32'hFFFF80FF);
    run_load("lw0", 3'd2, 32'h0, 32'h80FF7F01);

    // Test 4: latency 3.
    issue(1'b1, 1'b0, 3'd2, 32'h0, 32'd0);
    track(1'b1, lat, en_cnt, en_first, rd, er);
    check("l3_lat", lat, 5);
    check("l3_en_cnt", en_cnt, 1);
    check("l3_en_first", en_first, 1);
    check("l3_data", rd, 32'h80FF7F01);
    check("l3_err", er, 1'b0);
    step();

    // Test 5: misaligned and illegal.
    run_bad("lw_mis", 1'b0, 3'd2, 32'h2);
    run_bad("sh_mis", 1'b1, 3'd1, 32'h1);
    run_bad("ld_f7", 1'b0, 3'd7, 32'h0);
    run_bad("st_f4", 1'b1, 3'd4, 32'h0);

    // Test 6a: reset while the latency-3 unit is in WAIT.
    issue(1'b1, 1'b0, 3'd2, 32'h0, 32'd0);
    step();
    areset = 1'b1;
    #1;
    check("rstw_ready_gate", ready1, 1'b0);
    step();
    areset = 1'b0;
    #1;
    check("rstw_ready", ready3, 1'b1);
    check("rstw_rv", rv3, 1'b0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rv3) hits++;
    end
    check("rstw_no_resp", hits, 0);

    // Test 6b: request held through RESP is taken only in the next IDLE.
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_0020;
    req_wdata  = 32'h11223344;
    req_valid1 = 1'b1;
    step();
    check("bb_st_en", en1, 1'b1);
    check("bb_st_we", we1, 4'b1111);
    req_we = 1'b0;
    req_wdata = 32'd0;
    step();
    check("bb_resp_rv", rv1, 1'b1);
    check("bb_resp_ready", ready1, 1'b0);
    step();
    check("bb_idle_ready", ready1, 1'b1);
    check("bb_idle_en", en1, 1'b0);
    step();
    check("bb_ld_en", en1, 1'b1);
    check("bb_ld_we", we1, 4'b0000);
    req_valid1 = 1'b0;
    track(1'b0, lat, en_cnt, en_first, rd, er);
    check("bb_ld_lat", lat, 3);
    check("bb_ld_data", rd, 32'h11223344);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
